snake_body_tracker: RTL and testbench

- Owns the snake: head movement, segment shift register, growth, and wall/self/apple collision detection.
- Sits directly upstream of the apple generator. It supplies the packed body array and the one-cycle good-collision pulse, and consumes the current apple coordinate.
- Game-over and length outputs feed the top-level game FSM and score display.

---
 rtl/snake_body_tracker.sv | 244 ++++++++++++++++++++++++
 tb/tb_snake_body_tracker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_tracker.sv
// Snake state owner: head stepping, body shift register, growth, wall/self/apple hits.
// Latency: one cycle from a RUN tick to updated body/length/pulses; dir requests latch same cycle.
// Backpressure: none; tick/start/restart/dir_valid are single-cycle strobes, outputs always valid.
//
// Ports:
//   clk, reset (async, active-low)
//   tick        move strobe, honoured only in RUN
//   start       IDLE -> RUN
//   restart     OVER/WIN -> IDLE with reset contents
//   dir_valid   direction request strobe, dir = 00 up, 01 down, 10 left, 11 right
//   apple_cord  current apple {x,y}
//   body        packed {x,y} per slot, slot 0 (bits 7:0) is the head
//   length      active segment count
//   good_coll   one-cycle pulse, head landed on the apple
//   bad_coll    one-cycle pulse, wall or self hit
//   game_over   high in OVER
//   win         high in WIN
module snake_body_tracker #(
   parameter int MAX_LEN  = 50,
   parameter int INIT_LEN = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 start,
   input  logic                 restart,
   input  logic                 dir_valid,
   input  logic [1:0]           dir,
   input  logic [7:0]           apple_cord,
   output logic [MAX_LEN*8-1:0] body,
   output logic [5:0]           length,
   output logic                 good_coll,
   output logic                 bad_coll,
   output logic                 game_over,
   output logic                 win
);

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   localparam logic [7:0] HEAD_INIT = 8'h48;   // (4,8)
   localparam logic [7:0] BODY_INIT = 8'h38;   // (3,8)
   localparam logic [5:0] LEN_INIT  = 6'(INIT_LEN);
   localparam logic [5:0] LEN_MAX   = 6'(MAX_LEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_OVER = 2'd2,
      S_WIN  = 2'd3
   } state_t;

   state_t     r_state;
   logic [7:0] r_body [MAX_LEN];
   logic [5:0] r_len;
   logic [1:0] r_cur_dir;
   logic [1:0] r_pend_dir;
   logic       r_pend_lock;    // a request was accepted since the last move
   logic       r_good;
   logic       r_bad;
   logic       r_over;
   logic       r_win;

   logic       w_move;
   logic [3:0] w_hx;
   logic [3:0] w_hy;
   logic [7:0] w_nh;
   logic       w_wall;
   logic       w_grow;
   logic       w_self;
   logic       w_bad;
   logic [7:0] w_tail_new;
   logic [7:0] w_next_body [MAX_LEN];
   logic [5:0] w_len_inc;
   logic [1:0] w_ref_dir;
   logic       w_dir_acc;

   assign w_move    = (r_state == S_RUN) && tick;
   assign w_hx      = r_body[0][7:4];
   assign w_hy      = r_body[0][3:0];
   assign w_len_inc = r_len + 6'd1;

   // In a move cycle the pending direction becomes current, so a simultaneous
   // request is judged against it and opens a fresh request window.
   assign w_ref_dir = w_move ? r_pend_dir : r_cur_dir;
   assign w_dir_acc = dir_valid
                   && ((r_state == S_IDLE) || (r_state == S_RUN))
                   && (dir != {w_ref_dir[1], ~w_ref_dir[0]})
                   && (!r_pend_lock || w_move);

   always_comb begin
      w_nh   = r_body[0];
      w_wall = 1'b0;
      case (r_pend_dir)
         DIR_UP: begin
            w_nh   = {w_hx, w_hy - 4'd1};
            w_wall = (w_hy == 4'd0);
         end
         DIR_DOWN: begin
            w_nh   = {w_hx, w_hy + 4'd1};
            w_wall = (w_hy == 4'd15);
         end
         DIR_LEFT: begin
            w_nh   = {w_hx - 4'd1, w_hy};
            w_wall = (w_hx == 4'd0);
         end
         DIR_RIGHT: begin
            w_nh   = {w_hx + 4'd1, w_hy};
            w_wall = (w_hx == 4'd15);
         end
         default: begin
            w_nh   = r_body[0];
            w_wall = 1'b0;
         end
      endcase
   end

   assign w_grow = (w_nh == apple_cord) && !w_wall;

   // Without growth the tail slot vacates this move, so it is excluded.
   always_comb begin
      w_self = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (((i < int'(r_len) - 1) || (w_grow && (i < int'(r_len))))
             && (r_body[i] == w_nh)) begin
            w_self = 1'b1;
         end
      end
   end

   assign w_bad = w_wall || w_self;

   // Tail after a non-growing move is the segment just ahead of the old tail.
   always_comb begin
      w_tail_new = r_body[0];
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i == int'(r_len) - 2) begin
            w_tail_new = r_body[i];
         end
      end
   end

   // Growing: plain shift keeps the old tail in the new slot and in every unused slot.
   // Not growing: unused slots follow the new tail so they never hold a stale cell.
   always_comb begin
      for (int i = 0; i < MAX_LEN; i++) begin
         w_next_body[i] = r_body[i];
      end
      w_next_body[0] = w_nh;
      for (int i = 1; i < MAX_LEN; i++) begin
         if (!w_grow && (i >= int'(r_len))) begin
            w_next_body[i] = w_tail_new;
         end else begin
            w_next_body[i] = r_body[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         for (int i = 0; i < MAX_LEN; i++) begin
            r_body[i] <= (i == 0) ? HEAD_INIT : BODY_INIT;
         end
         r_len       <= LEN_INIT;
         r_cur_dir   <= DIR_RIGHT;
         r_pend_dir  <= DIR_RIGHT;
         r_pend_lock <= 1'b0;
         r_good      <= 1'b0;
         r_bad       <= 1'b0;
         r_over      <= 1'b0;
         r_win       <= 1'b0;
      end else begin
         r_good <= 1'b0;
         r_bad  <= 1'b0;

         if (w_move) begin
            r_cur_dir   <= r_pend_dir;
            r_pend_lock <= 1'b0;
         end
         if (w_dir_acc) begin
            r_pend_dir  <= dir;
            r_pend_lock <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (tick) begin
                  if (w_bad) begin
                     r_bad   <= 1'b1;
                     r_over  <= 1'b1;
                     r_state <= S_OVER;
                  end else begin
                     for (int i = 0; i < MAX_LEN; i++) begin
                        r_body[i] <= w_next_body[i];
                     end
                     if (w_grow) begin
                        r_good <= 1'b1;
                        r_len  <= w_len_inc;
                        if (w_len_inc == LEN_MAX) begin
                           r_win   <= 1'b1;
                           r_state <= S_WIN;
                        end
                     end
                  end
               end
            end
            S_OVER, S_WIN: begin
               if (restart) begin
                  r_state     <= S_IDLE;
                  for (int i = 0; i < MAX_LEN; i++) begin
                     r_body[i] <= (i == 0) ? HEAD_INIT : BODY_INIT;
                  end
                  r_len       <= LEN_INIT;
                  r_cur_dir   <= DIR_RIGHT;
                  r_pend_dir  <= DIR_RIGHT;
                  r_pend_lock <= 1'b0;
                  r_over      <= 1'b0;
                  r_win       <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < MAX_LEN; g++) begin : g_body
      assign body[g*8 +: 8] = r_body[g];
   end

   assign length    = r_len;
   assign good_coll = r_good;
   assign bad_coll  = r_bad;
   assign game_over = r_over;
   assign win       = r_win;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Scoreboard bench for snake_body_tracker: a 50-slot and a 4-slot instance.
// Stimulus pushes hand-computed expectations; a monitor pops them one cycle after each tick
// (or on an explicit snapshot request) and flags any pulse seen outside a tick response.
module tb_snake_body_tracker;

   typedef struct {
      logic [399:0] body;
      logic [5:0]   len;
      logic         good;
      logic         bad;
      logic         over;
      logic         win;
   } exp_t;

   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   logic [1:0] rst_s, tick_s, start_s, restart_s, dv_s, snap_s;
   logic [1:0] dir_s   [2];
   logic [7:0] apple_s [2];
   logic [1:0] tick_d = 2'b00;

   logic [399:0] body_a;
   logic [31:0]  body_b;
   logic [5:0]   len_a, len_b;
   logic         good_a, bad_a, over_a, win_a;
   logic         good_b, bad_b, over_b, win_b;

   exp_t qa[$];
   exp_t qb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   snake_body_tracker #(.MAX_LEN(50), .INIT_LEN(2)) u_a (
      .clk(clk), .reset(rst_s[0]), .tick(tick_s[0]), .start(start_s[0]),
      .restart(restart_s[0]), .dir_valid(dv_s[0]), .dir(dir_s[0]),
      .apple_cord(apple_s[0]), .body(body_a), .length(len_a),
      .good_coll(good_a), .bad_coll(bad_a), .game_over(over_a), .win(win_a)
   );

   snake_body_tracker #(.MAX_LEN(4), .INIT_LEN(2)) u_b (
      .clk(clk), .reset(rst_s[1]), .tick(tick_s[1]), .start(start_s[1]),
      .restart(restart_s[1]), .dir_valid(dv_s[1]), .dir(dir_s[1]),
      .apple_cord(apple_s[1]), .body(body_b), .length(len_b),
      .good_coll(good_b), .bad_coll(bad_b), .game_over(over_b), .win(win_b)
   );

   // segs lists occupied cells head first, right-aligned: 64'h584838 = (5,8),(4,8),(3,8).
   function automatic logic [399:0] mk(input logic [63:0] segs, input int n, input int maxlen);
      logic [399:0] r;
      logic [7:0]   t;
      r = '0;
      t = 8'h00;
      for (int i = 0; i < maxlen; i++) begin
         if (i < n) t = segs[(n-1-i)*8 +: 8];
         r[i*8 +: 8] = t;
      end
      return r;
   endfunction

   function automatic exp_t ex(input logic [63:0] segs, input int n, input int maxlen,
                               input logic g, input logic b, input logic o, input logic w);
      exp_t e;
      e.body = mk(segs, n, maxlen);
      e.len  = 6'(n);
      e.good = g;
      e.bad  = b;
      e.over = o;
      e.win  = w;
      return e;
   endfunction

   task automatic check(input int s);
      exp_t         e;
      logic [399:0] b;
      logic [5:0]   l;
      logic         g, bd, o, w;
      n_total++;
      if ((s == 0 && qa.size() == 0) || (s == 1 && qb.size() == 0)) begin
         $display("FAIL dut%0d no_expectation: output presented with empty scoreboard", s);
         return;
      end
      if (s == 0) begin
         e = qa.pop_front();
         b = body_a; l = len_a; g = good_a; bd = bad_a; o = over_a; w = win_a;
      end else begin
         e = qb.pop_front();
         b = {368'h0, body_b}; l = len_b; g = good_b; bd = bad_b; o = over_b; w = win_b;
      end
      if (b === e.body && l === e.len && g === e.good && bd === e.bad &&
          o === e.over && w === e.win) begin
         n_pass++;
      end else begin
         $display("FAIL dut%0d chk%0d: got len=%0d g=%b b=%b o=%b w=%b body=%h ; required len=%0d g=%b b=%b o=%b w=%b body=%h",
                  s, n_total, l, g, bd, o, w, b, e.len, e.good, e.bad, e.over, e.win, e.body);
      end
   endtask

   always @(posedge clk) tick_d <= tick_s;

   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (tick_d[s] || snap_s[s]) begin
            check(s);
         end else if ((s == 0 && (good_a || bad_a)) || (s == 1 && (good_b || bad_b))) begin
            n_total++;
            $display("FAIL dut%0d stray_pulse: good/bad high outside tick response, required 0", s);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input exp_t e);
      if (s == 0) qa.push_back(e);
      else        qb.push_back(e);
   endtask

   task automatic do_tick(input int s, input exp_t e);
      push(s, e);
      tick_s[s] = 1'b1;
      cyc();
      tick_s[s] = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic snap(input int s, input exp_t e);
      push(s, e);
      snap_s[s] = 1'b1;
      @(negedge clk);
      #1;
      snap_s[s] = 1'b0;
   endtask

   task automatic do_dir(input int s, input logic [1:0] d);
      dir_s[s] = d;
      dv_s[s]  = 1'b1;
      cyc();
      dv_s[s]  = 1'b0;
   endtask

   task automatic do_start(input int s);
      start_s[s] = 1'b1;
      cyc();
      start_s[s] = 1'b0;
   endtask

   task automatic do_restart(input int s);
      restart_s[s] = 1'b1;
      cyc();
      restart_s[s] = 1'b0;
   endtask

   task automatic do_reset(input int s, input exp_t e);
      rst_s[s] = 1'b0;
      snap(s, e);
      cyc();
      rst_s[s] = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      exp_t        ra, rb;
      logic [63:0] sg;
      rst_s = 2'b00; tick_s = 2'b00; start_s = 2'b00; restart_s = 2'b00;
      dv_s = 2'b00; snap_s = 2'b00;
      dir_s[0] = 2'b00; dir_s[1] = 2'b00;
      apple_s[0] = 8'hFF; apple_s[1] = 8'hFF;
      ra = ex(64'h4838, 2, 50, 0, 0, 0, 0);
      rb = ex(64'h4838, 2, 4, 0, 0, 0, 0);

      // reset state, then three straight moves to the right
      do_reset(0, ra);
      do_reset(1, rb);
      do_start(0);
      do_tick(0, ex(64'h5848, 2, 50, 0, 0, 0, 0));
      do_tick(0, ex(64'h6858, 2, 50, 0, 0, 0, 0));
      do_tick(0, ex(64'h7868, 2, 50, 0, 0, 0, 0));

      // first apple: grow to 3, pulse lasts one cycle
      do_reset(0, ra);
      apple_s[0] = 8'h58;
      do_start(0);
      do_tick(0, ex(64'h584838, 3, 50, 1, 0, 0, 0));
      apple_s[0] = 8'hFF;
      snap(0, ex(64'h584838, 3, 50, 0, 0, 0, 0));

      // reverse request ignored; first of two requests wins
      do_dir(0, 2'b10);
      do_tick(0, ex(64'h685848, 3, 50, 0, 0, 0, 0));
      do_dir(0, 2'b00);
      do_dir(0, 2'b01);
      do_tick(0, ex(64'h676858, 3, 50, 0, 0, 0, 0));
      do_tick(0, ex(64'h666768, 3, 50, 0, 0, 0, 0));

      // right wall at x=15, frozen in OVER, restart back to IDLE
      do_reset(0, ra);
      do_start(0);
      for (int k = 1; k <= 11; k++) begin
         sg = {48'h0, 4'(4 + k), 4'h8, 4'(3 + k), 4'h8};
         do_tick(0, ex(sg, 2, 50, 0, 0, 0, 0));
      end
      do_tick(0, ex(64'hF8E8, 2, 50, 0, 1, 1, 0));
      do_tick(0, ex(64'hF8E8, 2, 50, 0, 0, 1, 0));
      do_tick(0, ex(64'hF8E8, 2, 50, 0, 0, 1, 0));
      do_restart(0);
      snap(0, ra);
      do_tick(0, ra);

      // grow to 5 then curl into an occupied slot
      do_reset(0, ra);
      do_start(0);
      apple_s[0] = 8'h58;
      do_tick(0, ex(64'h584838, 3, 50, 1, 0, 0, 0));
      apple_s[0] = 8'h68;
      do_tick(0, ex(64'h68584838, 4, 50, 1, 0, 0, 0));
      apple_s[0] = 8'h78;
      do_tick(0, ex(64'h7868584838, 5, 50, 1, 0, 0, 0));
      apple_s[0] = 8'hFF;
      do_dir(0, 2'b01);
      do_tick(0, ex(64'h7978685848, 5, 50, 0, 0, 0, 0));
      do_dir(0, 2'b10);
      do_tick(0, ex(64'h6979786858, 5, 50, 0, 0, 0, 0));
      do_dir(0, 2'b00);
      do_tick(0, ex(64'h6979786858, 5, 50, 0, 1, 1, 0));

      // length 4: stepping into the vacating tail is legal
      do_reset(0, ra);
      do_start(0);
      apple_s[0] = 8'h58;
      do_tick(0, ex(64'h584838, 3, 50, 1, 0, 0, 0));
      apple_s[0] = 8'h68;
      do_tick(0, ex(64'h68584838, 4, 50, 1, 0, 0, 0));
      apple_s[0] = 8'hFF;
      do_dir(0, 2'b01);
      do_tick(0, ex(64'h69685848, 4, 50, 0, 0, 0, 0));
      do_dir(0, 2'b10);
      do_tick(0, ex(64'h59696858, 4, 50, 0, 0, 0, 0));
      do_dir(0, 2'b00);
      do_tick(0, ex(64'h58596968, 4, 50, 0, 0, 0, 0));

      // 4-slot instance: fill to MAX_LEN -> WIN, hold, restart
      do_start(1);
      apple_s[1] = 8'h58;
      do_tick(1, ex(64'h584838, 3, 4, 1, 0, 0, 0));
      apple_s[1] = 8'h68;
      do_tick(1, ex(64'h68584838, 4, 4, 1, 0, 0, 1));
      do_tick(1, ex(64'h68584838, 4, 4, 0, 0, 0, 1));
      do_restart(1);
      snap(1, rb);

      // reset lands right after a growing move: pulse and body cleared at once
      do_start(1);
      apple_s[1] = 8'h58;
      push(1, rb);
      tick_s[1] = 1'b1;
      cyc();
      tick_s[1] = 1'b0;
      rst_s[1]  = 1'b0;
      @(negedge clk);
      #1;
      cyc();
      rst_s[1] = 1'b1;
      do_tick(1, rb);

      repeat (3) cyc();
      n_total++;
      if (qa.size() == 0 && qb.size() == 0) n_pass++;
      else $display("FAIL leftover_expectations: got %0d/%0d pending, required 0/0", qa.size(), qb.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
